// File: rtl/muxn_pipe_pkg.sv
// Shared constants and helpers for the muxn_pipe selector family.
// The rr_mode port and its arbiter exist only when MUXN_PIPE_RR_EN is defined.
package muxn_pipe_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned MUX_MAX_IN = 32;

  // How the effective channel is chosen in a given cycle
  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } sel_mode_e;

  // Out-of-range selects fall through to the last channel
  function automatic int unsigned eff_channel(int unsigned sel, int unsigned num_in);
    return (sel < num_in) ? sel : num_in - 1;
  endfunction

endpackage

// File: rtl/muxn_rr_arb.sv
// Round-robin arbiter: grants the first requester above the last grant,
// wrapping at NUM_IN-1 back to 0. Built only when MUXN_PIPE_RR_EN is defined.
module muxn_rr_arb #(
  parameter int unsigned NUM_IN = 8,
  parameter int unsigned SELW   = $clog2(NUM_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] req,
  input  logic              advance,
  output logic [SELW-1:0]   grant_ch,
  output logic              grant_any
);

  logic [SELW-1:0] last_q, last_d;
  logic [SELW:0]   idx;

  // Rotating priority search starting one above the previous winner
  always_comb begin
    grant_ch  = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int unsigned i = 1; i <= NUM_IN; i++) begin
      idx = {1'b0, last_q} + (SELW+1)'(i);
      if (idx >= (SELW+1)'(NUM_IN)) idx = idx - (SELW+1)'(NUM_IN);
      if (!grant_any && req[idx]) begin
        grant_any = 1'b1;
        grant_ch  = idx[SELW-1:0];
      end
    end
    last_d = advance ? grant_ch : last_q;
  end

  // Last grant starts at the top channel so channel 0 wins first
  always_ff @(posedge clk) begin
    if (rst) last_q <= SELW'(NUM_IN - 1);
    else     last_q <= last_d;
  end

endmodule

// File: rtl/muxn_pipe.sv
// N-way data selector with one registered output stage and valid/ready
// handshakes on every input and on the output.
// Optional MUXN_PIPE_RR_EN adds rr_mode for round-robin channel choice.
module muxn_pipe
  import muxn_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = DATA_WIDTH,
  parameter int unsigned NUM_IN = 8,
  parameter int unsigned SELW   = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SELW-1:0]         sel,
`ifdef MUXN_PIPE_RR_EN
  input  logic                    rr_mode,
`endif
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SELW-1:0]         out_ch,
  output logic                    sel_err
);

  generate
    if (NUM_IN < 2 || NUM_IN > MUX_MAX_IN || WIDTH == 0) begin : g_bad_param
      $error("muxn_pipe: NUM_IN must be 2..MUX_MAX_IN and WIDTH nonzero");
    end
  endgenerate

  sel_mode_e       mode;
  logic            sel_oor;
  logic [SELW-1:0] sel_ch;
  logic [SELW-1:0] ch_c;
  logic            ready_en;
  logic            can_load;
  logic            load;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic             sel_err_q, sel_err_d;

  assign sel_oor = 32'(sel) >= NUM_IN;
  assign sel_ch  = SELW'(eff_channel(32'(sel), NUM_IN));

`ifdef MUXN_PIPE_RR_EN
  logic [SELW-1:0] rr_ch;
  logic            rr_any;

  assign mode = rr_mode ? MODE_RR : MODE_SEL;

  muxn_rr_arb #(
    .NUM_IN (NUM_IN),
    .SELW   (SELW)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (in_valid),
    .advance   (load && (mode == MODE_RR)),
    .grant_ch  (rr_ch),
    .grant_any (rr_any)
  );
`else
  assign mode = MODE_SEL;
`endif

  // Pick the effective channel; round-robin only offers ready to a requester
  always_comb begin
    ch_c     = sel_ch;
    ready_en = 1'b1;
`ifdef MUXN_PIPE_RR_EN
    if (mode == MODE_RR) begin
      ch_c     = rr_ch;
      ready_en = rr_any;
    end
`endif
  end

  // One-hot ready toward the effective channel when the register can take a beat
  always_comb begin
    can_load = !out_valid_q || out_ready;
    in_ready = '0;
    if (!rst && can_load && ready_en) in_ready[ch_c] = 1'b1;
    load = !rst && can_load && ready_en && in_valid[ch_c];
  end

  // Output register next state: load replaces, drain clears valid, stall holds
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    if (load) begin
      out_data_d  = in_data[ch_c*WIDTH +: WIDTH];
      out_ch_d    = ch_c;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    sel_err_d = sel_err_q | (load && (mode == MODE_SEL) && sel_oor);
  end

  // Output stage registers; a beat in flight is dropped by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_muxn_pipe.sv
// Scoreboard bench for muxn_pipe with NUM_IN=5, WIDTH=32.
// Round-robin scenarios are included when MUXN_PIPE_RR_EN is defined.
module tb_muxn_pipe;

  localparam int unsigned N  = 5;
  localparam int unsigned W  = 32;
  localparam int unsigned SW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  out_ch;
  logic           sel_err;
`ifdef MUXN_PIPE_RR_EN
  logic           rr_mode;
`endif

  muxn_pipe #(
    .WIDTH  (W),
    .NUM_IN (N),
    .SELW   (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
`ifdef MUXN_PIPE_RR_EN
    .rr_mode   (rr_mode),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  d;
    logic [SW-1:0] ch;
  } beat_t;

  beat_t       sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic          m_valid  = 1'b0;
  logic          m_err    = 1'b0;
  logic          was_rst  = 1'b0;
  int unsigned   m_last   = N - 1;

  // Reference model and scoreboard, evaluated mid-cycle
  always @(negedge clk) begin
    int unsigned c;
    logic        en;
    logic        can;
    logic        ld;
    logic        rr;
    logic [N-1:0] exp_rdy;
    beat_t       b;

    if (was_rst) begin
      check("rst_data", 64'(out_data), 64'd0);
      check("rst_ch", 64'(out_ch), 64'd0);
    end
    check("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid && sb.size() != 0) begin
      check("out_data", 64'(out_data), 64'(sb[0].d));
      check("out_ch", 64'(out_ch), 64'(sb[0].ch));
    end
    check("sel_err", 64'(sel_err), 64'(m_err));

    if (rst) begin
      check("rdy_in_rst", 64'(in_ready), 64'd0);
      sb.delete();
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_last  = N - 1;
      was_rst = 1'b1;
    end else begin
      was_rst = 1'b0;
      rr  = 1'b0;
`ifdef MUXN_PIPE_RR_EN
      rr  = rr_mode;
`endif
      can = !m_valid || out_ready;
      if (m_valid && out_ready && sb.size() != 0) void'(sb.pop_front());
      c  = (32'(sel) < N) ? 32'(sel) : N - 1;
      en = 1'b1;
      if (rr) begin
        en = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
          int unsigned j;
          j = (m_last + k) % N;
          if (!en && in_valid[j]) begin
            en = 1'b1;
            c  = j;
          end
        end
      end
      exp_rdy = '0;
      if (can && en) exp_rdy[c] = 1'b1;
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      ld = can && en && in_valid[c];
      if (ld) begin
        b.d  = 32'hA000_0000 + c;
        b.ch = SW'(c);
        sb.push_back(b);
        if (!rr && 32'(sel) >= N) m_err = 1'b1;
        if (rr) m_last = c;
      end
      m_valid = ld ? 1'b1 : (m_valid && !out_ready);
    end
  end

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < int'(N); i++) in_data[i*W +: W] = 32'hA000_0000 + i;
    rst = 1'b1; in_valid = '0; sel = '0; out_ready = 1'b1;
`ifdef MUXN_PIPE_RR_EN
    rr_mode = 1'b0;
`endif
    cyc(2);
    rst = 1'b0;

    // Basic select of channel 3
    sel = 3'd3; in_valid = 5'b01000; cyc(1);
    in_valid = '0; cyc(2);

    // Back-pressure on channel 1, then release with no bubble
    sel = 3'd1; in_valid = 5'b00010; cyc(1);
    out_ready = 1'b0; cyc(3);
    out_ready = 1'b1; cyc(1);
    in_valid = '0; cyc(2);

    // Out-of-range select falls through to channel 4 and sets sticky error
    sel = 3'd7; in_valid = 5'b10000; cyc(1);
    in_valid = '0; sel = 3'd0; cyc(3);

    // Streaming alternation 0,2,0,2
    in_valid = 5'b11111;
    sel = 3'd0; cyc(1);
    sel = 3'd2; cyc(1);
    sel = 3'd0; cyc(1);
    sel = 3'd2; cyc(1);
    in_valid = '0; cyc(2);

    // Randomised traffic
    for (int i = 0; i < 60; i++) begin
      sel       = 3'($urandom_range(0, 7));
      in_valid  = 5'($urandom);
      out_ready = 1'($urandom);
      cyc(1);
    end
    out_ready = 1'b1; in_valid = '0; cyc(2);

    // Reset while stalled
    sel = 3'd0; in_valid = 5'b00001; out_ready = 1'b0; cyc(2);
    rst = 1'b1; cyc(1);
    rst = 1'b0; in_valid = '0; cyc(2);
    out_ready = 1'b1; cyc(2);

`ifdef MUXN_PIPE_RR_EN
    // Round-robin across channels 0,2,4
    rst = 1'b1; cyc(1); rst = 1'b0;
    rr_mode = 1'b1; in_valid = 5'b10101; cyc(5);
    in_valid = '0; cyc(2);
    // Drop channel 2 after its first grant
    rst = 1'b1; cyc(1); rst = 1'b0;
    in_valid = 5'b10101; cyc(2);
    in_valid = 5'b10001; cyc(3);
    in_valid = '0; cyc(2);
    // Random traffic mixing modes
    for (int i = 0; i < 60; i++) begin
      rr_mode   = 1'($urandom);
      sel       = 3'($urandom_range(0, 7));
      in_valid  = 5'($urandom);
      out_ready = 1'($urandom);
      cyc(1);
    end
    rr_mode = 1'b0; out_ready = 1'b1; in_valid = '0; cyc(2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muxn_pipe.md
Name: muxn_pipe

Overview:
- Parametrised N-way data selector with a registered output stage and valid/ready handshake on every input and on the output.
- Generalises the fixed mux2..mux7 family to any input count and width.
- Adds one pipeline stage of buffering and back-pressure, so wide selects can sit between datapath stages without a combinational path.
- Used in the datapath wherever a select source must be retimed, e.g. writeback, operand and forwarding selection.

Parameters:
- WIDTH, `DataWidth (32): data width per channel.
- NUM_IN, 8: number of input channels, 2..32.
- SELW, $clog2(NUM_IN): width of sel.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  NUM_IN*WIDTH  flattened input channels; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  NUM_IN  per-channel valid.
- in_ready  out  NUM_IN  per-channel ready; at most one bit is high.
- sel  in  SELW  requested channel; sampled every cycle.
- out_data  out  WIDTH  registered output data.
- out_valid  out  1  output holds a beat.
- out_ready  in  1  downstream accepts.
- out_ch  out  SELW  index of the channel that produced out_data.
- sel_err  out  1  sticky flag: an out-of-range sel value was used in a transfer.

Behaviour:
- Effective channel: c = sel if sel < NUM_IN, else NUM_IN-1. Out-of-range selects fall through to the last input, as the fixed muxes did.
- Combinational ready: can_load = !out_valid || out_ready.
  - in_ready[c] = can_load.
  - All other in_ready bits are 0.
- Load event: can_load && in_valid[c]. On the next edge:
  - out_data <= channel c data; out_ch <= c; out_valid <= 1.
  - If sel >= NUM_IN, sel_err <= 1.
- Drain only: out_valid && out_ready with no load → out_valid <= 0. out_data and out_ch hold their last value.
- Simultaneous drain and load: the register is replaced in the same cycle. Full throughput, one beat per clock; no bubble.
- Stall: out_valid && !out_ready → out_data, out_ch and out_valid hold; all in_ready are 0.
- Latency: exactly 1 cycle from input acceptance to out_valid.
- sel may change every cycle. Only the value present in the load cycle matters. Non-selected channels never see ready, so their valid/data must hold (AXI-style rule; the block does not buffer them).
- Reset (rst=1 at an edge): out_valid=0, out_data=0, out_ch=0, sel_err=0; in_ready forced to 0 while rst is high.
  - A beat in flight when reset asserts is discarded. Upstream must retry after reset.
- sel_err clears only on reset.

Optional Feature:
- Macro MUXN_PIPE_RR_EN.
- Defined:
  - Adds input port rr_mode (1 bit).
  - When rr_mode=1, sel is ignored. c is chosen round-robin among asserted in_valid bits, searching upward from last_grant+1 with wrap at NUM_IN-1 → 0.
  - last_grant updates only on a load event and resets to NUM_IN-1, so channel 0 wins first.
  - sel_err is not set in rr_mode.
  - If no input is valid, no channel gets ready.
  - rr_mode switching mid-stream takes effect the same cycle; last_grant is preserved.
- Undefined: the port and the arbiter logic are absent; behaviour is select-only exactly as above.

Decomposition:
- Shared header (Newdefine.h) holds `DataWidth and a new `MuxMaxIn (32) for parameter range checks.
- One natural sub-module: muxn_rr_arb (NUM_IN-bit round-robin arbiter with rotate-priority encoder), instantiated only under MUXN_PIPE_RR_EN.
- The selection mux and output register stay in muxn_pipe.

Test Plan:
All scenarios use NUM_IN=5, WIDTH=32, channel i data = 32'hA000_0000+i.
1. Reset, then sel=3, in_valid=5'b01000, out_ready=1 → in_ready=5'b01000. Next cycle out_valid=1, out_data=A000_0003, out_ch=3.
2. Back-pressure: out_ready=0 for 3 cycles with sel=1 valid → all in_ready=0, out_data frozen. On out_ready=1, the ch1 beat is loaded the same cycle and appears next cycle with no bubble.
3. Out-of-range: sel=7, in_valid[4]=1 → out_data=A000_0004, out_ch=4, sel_err=1 and stays 1 until rst.
4. Streaming: sel alternates 0,2,0,2 with all valid and out_ready=1 → 4 beats on 4 consecutive cycles, out_ch 0,2,0,2.
5. Reset mid-stall: out_valid=1, out_ready=0, assert rst one cycle → out_valid=0, sel_err=0, out_data=0, in_ready=0 during rst.
6. (MUXN_PIPE_RR_EN) rr_mode=1, in_valid=5'b10101, out_ready=1 → grants 0,2,4,0,2; dropping valid[2] after its first grant → 0,2,4,0,4.
